// File: rtl/approx_seq_multiplier.sv
// approx_seq_multiplier
// Unsigned WIDTH x WIDTH iterative shift-add multiplier, one multiplier bit
// per cycle. Each operation selects exact or approximate accumulation; the
// approximate mode uses a lower-part-OR adder (LOA) on the low APPROX_BITS
// accumulator columns.
//
// Optional feature: define AM_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (result is unchanged).
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   in_valid    operands present
//   in_ready    block can accept operands (IDLE only)
//   in_a        multiplicand, unsigned
//   in_b        multiplier, unsigned
//   in_approx   1 = approximate (LOA), 0 = exact
//   out_valid   out_result holds a finished product (DONE)
//   out_ready   consumer takes the result
//   out_result  2*WIDTH-bit product
//   out_approx  mode the current result was computed in
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one shift-add step per cycle
// DONE  | result presented until out_ready
module approx_seq_multiplier #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_approx
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    // Index of the top OR column; clamped so APPROX_BITS=0 still elaborates.
    localparam int KI = (APPROX_BITS > 0) ? APPROX_BITS - 1 : 0;
    localparam logic [PW-1:0] LO_MASK = (PW'(1) << APPROX_BITS) - PW'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   acc_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]   cnt_q;
    logic            mode_q;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   sum;
    logic [PW-1:0]   hi_sum;
    logic            lo_carry;
    logic            last_step;
    logic            accept;

    always_comb begin
        pp = b_q[cnt_q] ? (a_q << cnt_q) : '0;
    end

    // LOA: low columns are ORed; the carry into the upper adder is the AND of
    // the top OR column, which partially recovers the lost carry chain.
    always_comb begin
        lo_carry = acc_q[KI] & pp[KI];
        hi_sum   = (acc_q >> APPROX_BITS) + (pp >> APPROX_BITS) + PW'(lo_carry);
        if (mode_q && (APPROX_BITS > 0))
            sum = (hi_sum << APPROX_BITS) | ((acc_q | pp) & LO_MASK);
        else
            sum = acc_q + pp;
    end

    always_comb begin
`ifdef AM_EARLY_EXIT_EN
        last_step = (cnt_q == CW'(WIDTH - 1)) ||
                    ((b_q >> (int'(cnt_q) + 1)) == '0);
`else
        last_step = (cnt_q == CW'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                a_q    <= PW'(in_a);
                b_q    <= in_b;
                mode_q <= in_approx;
                acc_q  <= '0;
                cnt_q  <= '0;
            end else if (state == RUN) begin
                acc_q <= sum;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign out_result = acc_q;
    assign out_approx = mode_q;

endmodule

// File: tb/tb_approx_seq_multiplier.sv
// Self-checking bench for approx_seq_multiplier (WIDTH=8, APPROX_BITS=4).
// Honours AM_EARLY_EXIT_EN when computing expected latency.
module tb_approx_seq_multiplier;

    localparam int W = 8;
    localparam int K = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            in_approx;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_result;
    logic            out_approx;

    int              errors = 0;
    int              checks = 0;
    bit              pending = 1'b0;
    logic [2*W-1:0]  exp_res = '0;
    bit              exp_mode = 1'b0;
    int              stale_seen = 0;

    approx_seq_multiplier #(.WIDTH(W), .APPROX_BITS(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_approx  (in_approx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_approx (out_approx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Product as defined by the arithmetic rules: shift-add over multiplier
    // bits, with the LOA addition rule applied when approximate.
    function automatic longint model(input longint a, input longint b, input bit ap);
        longint acc = 0;
        longint pp;
        longint c;
        longint p2 = longint'(1) << K;
        longint m  = longint'(1) << (2 * W);
        for (int i = 0; i < W; i++) begin
            pp = ((b >> i) & 1) != 0 ? (a << i) : 0;
            if (ap && K > 0) begin
                c   = ((acc >> (K - 1)) & 1) & ((pp >> (K - 1)) & 1);
                acc = (((acc / p2) + (pp / p2) + c) * p2 + ((acc | pp) % p2)) % m;
            end else begin
                acc = (acc + pp) % m;
            end
        end
        return acc;
    endfunction

    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef AM_EARLY_EXIT_EN
        if (b == '0) return 1;
        for (int i = W - 1; i >= 0; i--)
            if (b[i]) return i + 1;
`endif
        return W;
    endfunction

    // Every cycle a result is presented it must be expected, correct,
    // stable, and the input side must be closed.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!pending) stale_seen++;
            check("no_stray_valid", longint'(pending), 1);
            check("out_result", longint'(out_result), longint'(exp_res));
            check("out_approx", longint'(out_approx), longint'(exp_mode));
            check("in_ready_in_done", longint'(in_ready), 0);
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit m, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_op", longint'(in_ready), 1);
        in_a      = a;
        in_b      = b;
        in_approx = m;
        in_valid  = 1'b1;
        exp_res   = 16'(model(longint'(a), longint'(b), m));
        exp_mode  = m;
        pending   = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_a      = ~a;
        in_b      = ~b;
        in_approx = ~m;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 40);
        check("latency", longint'(n), longint'(exp_lat(b)));
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        pending   = 1'b0;
        @(negedge clk);
        check("out_valid_drop", longint'(out_valid), 0);
        check("in_ready_after", longint'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'd5;
        in_b      = 8'd5;
        in_approx = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_result", longint'(out_result), 0);
        check("rst_out_approx", longint'(out_approx), 0);
        in_valid = 1'b0;
        rst      = 1'b0;

        check("model_255x255_exact", model(255, 255, 0), 65025);
        check("model_15x3_approx", model(15, 3, 1), 47);
        check("model_15x3_exact", model(15, 3, 0), 45);
        check("model_12x1_approx", model(12, 1, 1), 12);
        check("model_3x7_exact", model(3, 7, 0), 21);

        do_op(8'd255, 8'd255, 1'b0, 0);
        do_op(8'd15,  8'd3,   1'b1, 0);
        do_op(8'd0,   8'd200, 1'b0, 0);
        do_op(8'd0,   8'd200, 1'b1, 0);
        do_op(8'd12,  8'd1,   1'b1, 0);
        do_op(8'd255, 8'd255, 1'b1, 1);
        do_op(8'd170, 8'd85,  1'b1, 2);
        do_op(8'd200, 8'd13,  1'b1, 5);
        do_op(8'd3,   8'd7,   1'b0, 0);
        do_op(8'd9,   8'd1,   1'b0, 0);
        do_op(8'd9,   8'h80,  1'b0, 0);
        do_op(8'd77,  8'd0,   1'b1, 0);

        // Reset during RUN cycle 3, with a competing request present.
        @(negedge clk);
        in_a      = 8'd100;
        in_b      = 8'd100;
        in_approx = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        pending   = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'd5;
        in_b      = 8'd5;
        in_approx = 1'b1;
        stale_seen = 0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_in_ready", longint'(in_ready), 1);
        check("abort_out_result", longint'(out_result), 0);
        check("abort_out_approx", longint'(out_approx), 0);
        repeat (20) @(negedge clk);
        check("abort_no_stale", longint'(stale_seen), 0);

        do_op(8'd6, 8'd7, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
